// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing a single alu_top between
// N requesters. One transaction at a time: grant, start the ALU, wait for done
// (or a timeout), then return the result to the granted requester.
module alu_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [3*N-1:0]   req_op,
    input  logic [8*N-1:0]   req_a,
    input  logic [8*N-1:0]   req_b,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     rsp_valid,
    output logic [15:0]      rsp_result,
    output logic             rsp_timeout,
    output logic             busy,
    output logic             alu_start,
    output logic [2:0]       alu_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic             alu_done,
    input  logic [15:0]      alu_result
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]  ONE   = N'(1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state_q, state_d;

    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  last_grant_q, last_grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   ack_q, ack_d;
    logic [N-1:0]   rsp_valid_q, rsp_valid_d;
    logic [15:0]    rsp_result_q, rsp_result_d;
    logic           rsp_timeout_q, rsp_timeout_d;
    logic           busy_q, busy_d;
    logic           alu_start_q, alu_start_d;
    logic [2:0]     alu_op_q, alu_op_d;
    logic [7:0]     alu_a_q, alu_a_d;
    logic [7:0]     alu_b_q, alu_b_d;

    logic           pick_valid;
    logic [GW-1:0]  pick_idx;
    int unsigned    cand;
    int unsigned    sel;

    // Round-robin pick: first pending request after last_grant, with wrap.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 0; i < unsigned'(N); i++) begin
            cand = (32'(last_grant_q) + 32'd1 + i) % unsigned'(N);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(cand);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in WAIT a done takes precedence over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (alu_done || (cnt_q == LIMIT)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; every output is registered from these.
    always_comb begin
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        rsp_valid_d   = '0;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        alu_start_d   = 1'b0;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        busy_d        = (state_d != IDLE);
        sel           = 32'(pick_idx);
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d  = pick_idx;
                    ack_d    = ONE << pick_idx;
                    alu_op_d = req_op[3*sel +: 3];
                    alu_a_d  = req_a[8*sel +: 8];
                    alu_b_d  = req_b[8*sel +: 8];
                end
            end
            ISSUE: begin
                alu_start_d = 1'b1;
                cnt_d       = '0;
            end
            WAIT: begin
                if (alu_done) begin
                    rsp_result_d  = alu_result;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = ONE << grant_q;
                end else if (cnt_q == LIMIT) begin
                    rsp_result_d  = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = ONE << grant_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                last_grant_d = grant_q;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q       <= '0;
            last_grant_q  <= GW'(N - 1);
            cnt_q         <= '0;
            ack_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            alu_start_q   <= 1'b0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
        end else begin
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            alu_start_q   <= alu_start_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
        end
    end

    assign ack         = ack_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;
    assign alu_start   = alu_start_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a stub ALU of programmable latency.
// Stub op codes: 0 add, 1 sub, 2 mul, 3 div, others return 16'hBEEF.
module tb_alu_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [3*N-1:0]  req_op;
    logic [8*N-1:0]  req_a;
    logic [8*N-1:0]  req_b;
    logic [N-1:0]    ack;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_result;
    logic            rsp_timeout;
    logic            busy;
    logic            alu_start;
    logic [2:0]      alu_op;
    logic [7:0]      alu_a;
    logic [7:0]      alu_b;
    logic            alu_done;
    logic [15:0]     alu_result;

    int errors = 0;
    int checks = 0;

    // stub ALU controls
    int   lat  = 1;
    logic hang = 1'b0;
    logic pend;
    int   stub_cnt;

    // cumulative monitors for requester 1
    int ack1_seen = 0;
    int rsp1_seen = 0;

    alu_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .busy(busy), .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Stub ALU: latches operands on start, pulses done after lat cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_done   <= 1'b0;
            alu_result <= 16'h0;
            pend       <= 1'b0;
            stub_cnt   <= 0;
        end else begin
            alu_done <= 1'b0;
            if (alu_start) begin
                pend     <= 1'b1;
                stub_cnt <= lat;
                case (alu_op)
                    3'd0: alu_result <= 16'(alu_a) + 16'(alu_b);
                    3'd1: alu_result <= 16'(alu_a) - 16'(alu_b);
                    3'd2: alu_result <= 16'(alu_a) * 16'(alu_b);
                    3'd3: alu_result <= (alu_b == 8'd0) ? 16'h0 : 16'(alu_a / alu_b);
                    default: alu_result <= 16'hBEEF;
                endcase
            end else if (pend) begin
                if (hang) begin
                    pend <= 1'b0;
                end else if (stub_cnt <= 1) begin
                    alu_done <= 1'b1;
                    pend     <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ack[1]) ack1_seen <= ack1_seen + 1;
        if (rsp_valid[1]) rsp1_seen <= rsp1_seen + 1;
    end

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        req   = '0;
        hang  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Both wait tasks return -1 if the bound expires.
    task automatic wait_ack(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (ack != '0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (rsp_valid != '0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        req    = '0;
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        #1;
        checks++;
        if ({ack, rsp_valid, rsp_result, rsp_timeout, busy, alu_start, alu_op, alu_a, alu_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b rsp_valid=%b result=%h busy=%b start=%b", ack, rsp_valid, rsp_result, busy, alu_start);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack, busy, alu_start} !== '0) begin
            errors++;
            $display("FAIL idle_no_req: ack=%b busy=%b start=%b, want all 0", ack, busy, alu_start);
        end
    endtask

    task automatic test_single();
        int c;
        reset_dut();
        lat = 2;
        set_req(0, 3'd0, 8'd25, 8'd17);
        req = 4'b0001;
        @(posedge clk); #1;
        checks++;
        if (ack !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: ack=%b busy=%b, want ack=0001 busy=1", ack, busy);
        end
        req = '0;
        @(posedge clk); #1;
        checks++;
        if (alu_start !== 1'b1 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_start: start=%b ack=%b, want start=1 ack=0000", alu_start, ack);
        end
        checks++;
        if ({alu_op, alu_a, alu_b} !== {3'd0, 8'd25, 8'd17}) begin
            errors++;
            $display("FAIL single_operands: op=%0d a=%0d b=%0d, want 0 25 17", alu_op, alu_a, alu_b);
        end
        @(posedge clk); #1;
        checks++;
        if (alu_start !== 1'b0) begin
            errors++;
            $display("FAIL single_start_pulse: start=%b, want 0", alu_start);
        end
        wait_rsp(c);
        checks++;
        if (c < 0 || rsp_valid !== 4'b0001 || rsp_result !== 16'd42 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: cyc=%0d valid=%b result=%0d to=%b, want 0001 42 0", c, rsp_valid, rsp_result, rsp_timeout);
        end
    endtask

    task automatic test_simultaneous();
        int c;
        reset_dut();
        lat = 1;
        set_req(0, 3'd2, 8'd6, 8'd9);
        set_req(2, 3'd1, 8'd42, 8'd15);
        req = 4'b0101;
        @(posedge clk); #1;
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL simul_first_ack: ack=%b, want 0001", ack);
        end
        req = 4'b0100;
        wait_rsp(c);
        checks++;
        if (c < 0 || rsp_valid !== 4'b0001 || rsp_result !== 16'd54) begin
            errors++;
            $display("FAIL simul_rsp0: cyc=%0d valid=%b result=%0d, want 0001 54", c, rsp_valid, rsp_result);
        end
        wait_ack(c);
        checks++;
        if (c < 0 || ack !== 4'b0100) begin
            errors++;
            $display("FAIL simul_second_ack: cyc=%0d ack=%b, want 0100", c, ack);
        end
        req = '0;
        wait_rsp(c);
        checks++;
        if (c < 0 || rsp_valid !== 4'b0100 || rsp_result !== 16'd27) begin
            errors++;
            $display("FAIL simul_rsp2: cyc=%0d valid=%b result=%0d, want 0100 27", c, rsp_valid, rsp_result);
        end
    endtask

    task automatic test_fairness();
        int c;
        logic [N-1:0] exp_g;
        logic [15:0]  exp_r;
        reset_dut();
        lat = 1;
        set_req(0, 3'd0, 8'd1, 8'd1);
        set_req(1, 3'd0, 8'd2, 8'd3);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            exp_r = (k % 2 == 0) ? 16'd2 : 16'd5;
            wait_ack(c);
            checks++;
            if (c < 0 || ack !== exp_g) begin
                errors++;
                $display("FAIL fair_ack%0d: cyc=%0d ack=%b, want %b", k, c, ack, exp_g);
            end
            wait_rsp(c);
            checks++;
            if (c < 0 || rsp_valid !== exp_g || rsp_result !== exp_r) begin
                errors++;
                $display("FAIL fair_rsp%0d: cyc=%0d valid=%b result=%0d, want %b %0d", k, c, rsp_valid, rsp_result, exp_g, exp_r);
            end
        end
        req = '0;
    endtask

    task automatic test_timeout();
        int c;
        int n;
        reset_dut();
        lat = 3;
        set_req(1, 3'd0, 8'd20, 8'd22);
        req = 4'b0010;
        wait_ack(c);
        req = '0;
        wait_rsp(c);
        checks++;
        if (c < 0 || rsp_result !== 16'd42) begin
            errors++;
            $display("FAIL to_pre_rsp: cyc=%0d result=%0d, want 42", c, rsp_result);
        end
        // hung ALU
        hang = 1'b1;
        set_req(1, 3'd0, 8'd5, 8'd5);
        req = 4'b0010;
        wait_ack(c);
        req = '0;
        @(posedge clk); #1;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (rsp_valid != '0) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL to_latency: got %0d cycles, want %0d", n, TIMEOUT);
        end
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_timeout !== 1'b1 || rsp_result !== 16'd0) begin
            errors++;
            $display("FAIL to_rsp: valid=%b to=%b result=%0d, want 0010 1 0", rsp_valid, rsp_timeout, rsp_result);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_hold: valid=%b to=%b, want 0000 1", rsp_valid, rsp_timeout);
        end
        // done arrives on the last allowed WAIT cycle: done wins
        hang = 1'b0;
        lat  = TIMEOUT - 2;
        set_req(1, 3'd0, 8'd4, 8'd6);
        req = 4'b0010;
        wait_ack(c);
        req = '0;
        @(posedge clk); #1;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (rsp_valid != '0) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != TIMEOUT || rsp_timeout !== 1'b0 || rsp_result !== 16'd10) begin
            errors++;
            $display("FAIL to_done_wins: cyc=%0d to=%b result=%0d, want %0d 0 10", n, rsp_timeout, rsp_result, TIMEOUT);
        end
    endtask

    task automatic test_reset_mid_wait();
        int c;
        int r1;
        reset_dut();
        lat = 20;
        set_req(1, 3'd3, 8'd100, 8'd4);
        req = 4'b0010;
        wait_ack(c);
        req = '0;
        repeat (4) @(posedge clk);
        #1;
        r1 = rsp1_seen;
        set_req(0, 3'd0, 8'd1, 8'd2);
        set_req(3, 3'd1, 8'd9, 8'd4);
        req   = 4'b1001;
        reset = 1'b1;
        #1;
        checks++;
        if ({ack, rsp_valid, rsp_result, rsp_timeout, busy, alu_start, alu_op, alu_a, alu_b} !== '0) begin
            errors++;
            $display("FAIL midwait_reset: ack=%b valid=%b busy=%b op=%0d a=%0d", ack, rsp_valid, busy, alu_op, alu_a);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wait_ack(c);
        checks++;
        if (c < 0 || ack !== 4'b0001) begin
            errors++;
            $display("FAIL midwait_first_ack: cyc=%0d ack=%b, want 0001", c, ack);
        end
        req = 4'b1000;
        wait_rsp(c);
        checks++;
        if (c < 0 || rsp_valid !== 4'b0001 || rsp_result !== 16'd3) begin
            errors++;
            $display("FAIL midwait_rsp0: cyc=%0d valid=%b result=%0d, want 0001 3", c, rsp_valid, rsp_result);
        end
        wait_ack(c);
        checks++;
        if (c < 0 || ack !== 4'b1000) begin
            errors++;
            $display("FAIL midwait_ack3: cyc=%0d ack=%b, want 1000", c, ack);
        end
        req = '0;
        wait_rsp(c);
        checks++;
        if (c < 0 || rsp_valid !== 4'b1000 || rsp_result !== 16'd5) begin
            errors++;
            $display("FAIL midwait_rsp3: cyc=%0d valid=%b result=%0d, want 1000 5", c, rsp_valid, rsp_result);
        end
        checks++;
        if (rsp1_seen != r1) begin
            errors++;
            $display("FAIL midwait_no_rsp1: got %0d extra rsp_valid[1], want 0", rsp1_seen - r1);
        end
    endtask

    task automatic test_withdraw();
        int c;
        int a1;
        int r1;
        reset_dut();
        lat = 10;
        a1 = ack1_seen;
        r1 = rsp1_seen;
        set_req(0, 3'd0, 8'd7, 8'd8);
        req = 4'b0001;
        wait_ack(c);
        req = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_req(1, 3'd0, 8'd50, 8'd50);
        req = 4'b0010;
        @(posedge clk); #1;
        req = '0;
        wait_rsp(c);
        checks++;
        if (c < 0 || rsp_valid !== 4'b0001 || rsp_result !== 16'd15) begin
            errors++;
            $display("FAIL withdraw_rsp0: cyc=%0d valid=%b result=%0d, want 0001 15", c, rsp_valid, rsp_result);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (ack1_seen != a1 || rsp1_seen != r1) begin
            errors++;
            $display("FAIL withdraw_no_req1: ack1=%0d rsp1=%0d, want 0 0", ack1_seen - a1, rsp1_seen - r1);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int n;
        reset_dut();
        lat = 2;
        set_req(2, 3'd7, 8'd3, 8'd4);
        req = 4'b0100;
        wait_ack(c);
        @(posedge clk); #1;
        checks++;
        if (alu_start !== 1'b1 || {alu_op, alu_a, alu_b} !== {3'd7, 8'd3, 8'd4}) begin
            errors++;
            $display("FAIL b2b_passthrough: start=%b op=%0d a=%0d b=%0d, want 1 7 3 4", alu_start, alu_op, alu_a, alu_b);
        end
        n = -1;
        for (int i = 2; i <= 100; i++) begin
            @(posedge clk); #1;
            if (ack != '0) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 5 + lat || ack !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_interval: ack-to-ack=%0d ack=%b, want %0d 0100", n, ack, 5 + lat);
        end
        checks++;
        if (rsp_result !== 16'hBEEF || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: result=%h to=%b, want beef 0", rsp_result, rsp_timeout);
        end
        req = '0;
        wait_rsp(c);
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_reset_mid_wait();
        test_withdraw();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
